// File: rtl/osd_uart_16550_host.sv
// Host-side initiator for a 16550-style register file: programs the line after
// reset, then polls LSR and moves bytes between the RBR/THR registers and byte streams.
module osd_uart_16550_host #(
    parameter logic [15:0] DIVISOR  = 16'h0001,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  IER_VAL  = 8'h00,
    parameter logic [7:0]  FCR_VAL  = 8'h07,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       bus_req,
    output logic [2:0] bus_addr,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    input  logic       irq,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       init_done,
    output logic [3:0] fsm_state
);

    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    localparam logic [2:0] A_RBR_THR = 3'd0;
    localparam logic [2:0] A_IER_DLM = 3'd1;
    localparam logic [2:0] A_FCR     = 3'd2;
    localparam logic [2:0] A_LCR     = 3'd3;
    localparam logic [2:0] A_LSR     = 3'd5;

    typedef enum logic [3:0] {
        INIT_LCRD = 4'd0,
        INIT_DLL  = 4'd1,
        INIT_DLM  = 4'd2,
        INIT_LCR  = 4'd3,
        INIT_IER  = 4'd4,
        INIT_FCR  = 4'd5,
        POLL      = 4'd6,
        RD_RBR    = 4'd7,
        WR_THR    = 4'd8,
        GAP       = 4'd9
    } state_t;

    // Handshake: an access is open while bus_req=1; addr/write/wdata are only
    // loaded when a new access is issued, and it closes on the edge after a
    // cycle with bus_req=1 and bus_ack=1. Issue only happens from bus_req=0.
    state_t           state, state_n;
    logic             req_n, write_n, tx_ready_n, rx_valid_n, init_done_n;
    logic [2:0]       addr_n;
    logic [7:0]       wdata_n, rx_data_n, thr_byte, thr_byte_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;

    logic [2:0] acc_addr;
    logic       acc_write;
    logic [7:0] acc_wdata;

    assign fsm_state = state;

    always_comb begin
        acc_addr  = A_LSR;
        acc_write = 1'b0;
        acc_wdata = 8'h00;
        case (state)
            INIT_LCRD: begin acc_addr = A_LCR;     acc_write = 1'b1; acc_wdata = {1'b1, LCR_VAL[6:0]}; end
            INIT_DLL:  begin acc_addr = A_RBR_THR; acc_write = 1'b1; acc_wdata = DIVISOR[7:0]; end
            INIT_DLM:  begin acc_addr = A_IER_DLM; acc_write = 1'b1; acc_wdata = DIVISOR[15:8]; end
            INIT_LCR:  begin acc_addr = A_LCR;     acc_write = 1'b1; acc_wdata = {1'b0, LCR_VAL[6:0]}; end
            INIT_IER:  begin acc_addr = A_IER_DLM; acc_write = 1'b1; acc_wdata = IER_VAL; end
            INIT_FCR:  begin acc_addr = A_FCR;     acc_write = 1'b1; acc_wdata = FCR_VAL; end
            RD_RBR:    begin acc_addr = A_RBR_THR; end
            WR_THR:    begin acc_addr = A_RBR_THR; acc_write = 1'b1; acc_wdata = thr_byte; end
            default:   begin acc_addr = A_LSR; end
        endcase
    end

    always_comb begin
        state_n     = state;
        req_n       = bus_req;
        addr_n      = bus_addr;
        write_n     = bus_write;
        wdata_n     = bus_wdata;
        tx_ready_n  = 1'b0;
        rx_valid_n  = rx_valid;
        rx_data_n   = rx_data;
        init_done_n = init_done;
        thr_byte_n  = thr_byte;
        gap_cnt_n   = gap_cnt;

        if (rx_valid && rx_ready) begin
            rx_valid_n = 1'b0;
        end

        if (bus_req) begin
            if (bus_ack) begin
                req_n = 1'b0;
                case (state)
                    INIT_LCRD: state_n = INIT_DLL;
                    INIT_DLL:  state_n = INIT_DLM;
                    INIT_DLM:  state_n = INIT_LCR;
                    INIT_LCR:  state_n = INIT_IER;
                    INIT_IER:  state_n = INIT_FCR;
                    INIT_FCR: begin
                        state_n     = POLL;
                        init_done_n = 1'b1;
                    end
                    POLL: begin
                        // RX wins over TX; a full holding register blocks the RBR read.
                        if (bus_rdata[0] && !rx_valid) begin
                            state_n = RD_RBR;
                        end else if (bus_rdata[5] && tx_valid) begin
                            thr_byte_n = tx_data;
                            state_n    = WR_THR;
                        end else begin
                            gap_cnt_n = GAP_LOAD;
                            state_n   = GAP;
                        end
                    end
                    RD_RBR: begin
                        rx_data_n  = bus_rdata;
                        rx_valid_n = 1'b1;
                        state_n    = POLL;
                    end
                    WR_THR: begin
                        tx_ready_n = 1'b1;
                        state_n    = POLL;
                    end
                    default: state_n = POLL;
                endcase
            end
        end else if (state == GAP) begin
            // GAP cycles are themselves idle, so the poll is issued directly on
            // the last gap edge; this makes the idle count equal max(POLL_GAP,1).
            if (irq || gap_cnt <= GAP_ONE) begin
                state_n   = POLL;
                gap_cnt_n = '0;
                req_n     = 1'b1;
                addr_n    = A_LSR;
                write_n   = 1'b0;
                wdata_n   = 8'h00;
            end else begin
                gap_cnt_n = gap_cnt - GAP_ONE;
            end
        end else begin
            req_n   = 1'b1;
            addr_n  = acc_addr;
            write_n = acc_write;
            wdata_n = acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_LCRD;
            bus_req   <= 1'b0;
            bus_addr  <= 3'd0;
            bus_write <= 1'b0;
            bus_wdata <= 8'h00;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            init_done <= 1'b0;
            thr_byte  <= 8'h00;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            bus_req   <= req_n;
            bus_addr  <= addr_n;
            bus_write <= write_n;
            bus_wdata <= wdata_n;
            tx_ready  <= tx_ready_n;
            rx_valid  <= rx_valid_n;
            rx_data   <= rx_data_n;
            init_done <= init_done_n;
            thr_byte  <= thr_byte_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

endmodule

// File: tb/tb_osd_uart_16550_host.sv
// Directed bench for osd_uart_16550_host: a register-file responder with
// programmable ack delay logs every completed access for later comparison.
module tb_osd_uart_16550_host;

    localparam logic [15:0] DIV = 16'h0102;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_req, bus_write, bus_ack, irq;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, init_done;
    logic [7:0] tx_data, rx_data;
    logic [3:0] fsm_state;

    always #5 clk = ~clk;

    osd_uart_16550_host #(
        .DIVISOR (DIV),
        .LCR_VAL (8'h03),
        .IER_VAL (8'h00),
        .FCR_VAL (8'h07),
        .POLL_GAP(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_write(bus_write),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .irq      (irq),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .init_done(init_done),
        .fsm_state(fsm_state)
    );

    typedef struct {
        logic [2:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         start;
        int         cyc;
    } acc_t;

    acc_t        log_q[$];
    logic [11:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int start_cyc = 0;
    int stab_err = 0;
    int idle_err = 0;
    int txr_cnt = 0;
    logic [7:0] lsr_val, rbr_val;
    logic       prev_req = 1'b0, prev_ack = 1'b0, prev_wr = 1'b0;
    logic [2:0] prev_addr = 3'd0;
    logic [7:0] prev_wd = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst) cyc = 0;
        else      cyc = cyc + 1;
    end

    // Responder: acts mid-cycle, acks after ack_delay wait cycles, logs completed accesses.
    always @(negedge clk) begin
        acc_t e;
        if (tx_ready) txr_cnt++;
        if (!rst) begin
            bus_ack   = 1'b0;
            bus_rdata = 8'hFF;
            wait_cnt  = 0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            if (bus_req) begin
                if (prev_req && !prev_ack &&
                    {bus_addr, bus_write, bus_wdata} != {prev_addr, prev_wr, prev_wd}) stab_err++;
                if (prev_req && prev_ack) idle_err++;
                if (!prev_req) start_cyc = cyc;
                if (wait_cnt >= ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_write ? 8'hFF :
                                (bus_addr == 3'd5) ? lsr_val :
                                (bus_addr == 3'd0) ? rbr_val : 8'h00;
                    e.addr  = bus_addr;
                    e.wr    = bus_write;
                    e.wdata = bus_wdata;
                    e.rdata = bus_rdata;
                    e.start = start_cyc;
                    e.cyc   = cyc;
                    log_q.push_back(e);
                    wait_cnt = 0;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = 8'hFF;
                    wait_cnt++;
                end
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 8'hFF;
                wait_cnt  = 0;
            end
            prev_req  = bus_req;
            prev_ack  = bus_ack;
            prev_addr = bus_addr;
            prev_wr   = bus_write;
            prev_wd   = bus_wdata;
        end
    end

    task automatic pulse_rx_ready();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Called in cycle 0, just after reset release.
    task automatic init_check();
        acc_t e;
        exp_q.delete();
        exp_q.push_back({3'd3, 1'b1, 8'h83});
        exp_q.push_back({3'd0, 1'b1, 8'h02});
        exp_q.push_back({3'd1, 1'b1, 8'h01});
        exp_q.push_back({3'd3, 1'b1, 8'h03});
        exp_q.push_back({3'd1, 1'b1, 8'h00});
        exp_q.push_back({3'd2, 1'b1, 8'h07});
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c <= 12) check_val($sformatf("init_req_c%0d", c), bus_req, (c % 2 == 1));
            if (c == 11) check_val("init_done_c11", init_done, 0);
            if (c == 12) begin
                check_val("init_done_c12", init_done, 1);
                check_val("state_poll_c12", fsm_state, 6);
            end
        end
        check_val("init_log_len", log_q.size(), 7);
        for (int i = 0; i < 6; i++) begin
            if (log_q.size() > 0 && exp_q.size() > 0) begin
                e = log_q.pop_front();
                check_val($sformatf("init_wr%0d", i), {e.addr, e.wr, e.wdata}, exp_q.pop_front());
                check_val($sformatf("init_cyc%0d", i), e.cyc, 2 * i + 1);
            end
        end
        if (log_q.size() > 0) begin
            e = log_q.pop_front();
            check_val("first_lsr", {e.addr, e.wr}, {3'd5, 1'b0});
            check_val("first_lsr_cyc", e.cyc, 13);
        end
    endtask

    task automatic measure_gap(input bit use_irq, output int idle);
        int g;
        idle = 0;
        g = 0;
        while (!(bus_req && bus_ack && bus_addr == 3'd5) && g < 100) begin
            tick();
            g++;
        end
        check_val(use_irq ? "gap_irq_find_poll" : "gap_find_poll", (g < 100), 1);
        tick();
        g = 0;
        while (!bus_req && g < 20) begin
            idle++;
            if (use_irq) irq = 1'b1;
            tick();
            irq = 1'b0;
            g++;
        end
    endtask

    initial begin
        int g, n, t0, idle;
        rst = 1'b0; irq = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        lsr_val = 8'h00; rbr_val = 8'h00;
        repeat (3) tick();

        check_val("rst_req", bus_req, 0);
        check_val("rst_addr", bus_addr, 0);
        check_val("rst_write", bus_write, 0);
        check_val("rst_wdata", bus_wdata, 0);
        check_val("rst_tx_ready", tx_ready, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_init_done", init_done, 0);
        check_val("rst_state", fsm_state, 0);

        // 1: init sequence
        log_q.delete();
        rst = 1'b1;
        init_check();

        // 2: RX path and backpressure
        lsr_val = 8'h01; rbr_val = 8'h5A;
        g = 0;
        while (!rx_valid && g < 60) begin tick(); g++; end
        check_val("rx1_valid", rx_valid, 1);
        check_val("rx1_data", rx_data, 8'h5A);
        log_q.delete();
        repeat (40) tick();
        n = 0;
        foreach (log_q[i]) if (log_q[i].addr == 3'd0) n++;
        check_val("rx_bp_no_rbr", n, 0);
        check_val("rx_bp_polls", (log_q.size() > 2), 1);
        check_val("rx_bp_hold", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rbr_val = 8'hA5;
        log_q.delete();
        pulse_rx_ready();
        check_val("rx_cleared", rx_valid, 0);
        g = 0;
        while (!rx_valid && g < 40) begin tick(); g++; end
        check_val("rx2_data", {rx_valid, rx_data}, {1'b1, 8'hA5});
        check_val("rx2_log_len", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check_val("rx2_seq0", {log_q[0].addr, log_q[0].wr}, {3'd5, 1'b0});
            check_val("rx2_seq1", {log_q[1].addr, log_q[1].wr}, {3'd0, 1'b0});
        end
        lsr_val = 8'h00;
        pulse_rx_ready();
        check_val("rx2_drained", rx_valid, 0);
        repeat (10) tick();

        // 3: TX path
        log_q.delete();
        t0 = txr_cnt;
        lsr_val = 8'h60; tx_data = 8'h41; tx_valid = 1'b1;
        g = 0;
        while (!tx_ready && g < 40) begin tick(); g++; end
        tx_valid = 1'b0;
        check_val("tx1_ready", tx_ready, 1);
        if (log_q.size() > 0) begin
            check_val("tx1_write", {log_q[$].addr, log_q[$].wr, log_q[$].wdata}, {3'd0, 1'b1, 8'h41});
            check_val("tx1_ready_lat", cyc - log_q[$].cyc, 1);
        end
        tick();
        check_val("tx1_pulse_end", tx_ready, 0);
        repeat (30) tick();
        n = 0;
        foreach (log_q[i]) if (log_q[i].wr) n++;
        check_val("tx1_one_write", n, 1);
        check_val("tx1_one_pulse", txr_cnt - t0, 1);
        lsr_val = 8'h00;

        // 4: RX before TX when both are ready
        repeat (5) tick();
        log_q.delete();
        rbr_val = 8'hC3; tx_data = 8'h33; tx_valid = 1'b1; lsr_val = 8'h61;
        g = 0;
        while (!tx_ready && g < 60) begin tick(); g++; end
        tx_valid = 1'b0; lsr_val = 8'h00;
        check_val("prio_len", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            check_val("prio0", {log_q[0].addr, log_q[0].wr}, {3'd5, 1'b0});
            check_val("prio1", {log_q[1].addr, log_q[1].wr}, {3'd0, 1'b0});
            check_val("prio2", {log_q[2].addr, log_q[2].wr}, {3'd5, 1'b0});
            check_val("prio3", {log_q[3].addr, log_q[3].wr, log_q[3].wdata}, {3'd0, 1'b1, 8'h33});
        end
        check_val("prio_rx", {rx_valid, rx_data}, {1'b1, 8'hC3});
        pulse_rx_ready();

        // 5: delayed ack, tx_valid drop mid-write, poll gap and irq
        ack_delay = 3; stab_err = 0; idle_err = 0;
        repeat (10) tick();
        log_q.delete();
        t0 = txr_cnt;
        lsr_val = 8'h60; tx_data = 8'h7E; tx_valid = 1'b1;
        g = 0;
        while (!(bus_req && bus_write && bus_addr == 3'd0) && g < 60) begin tick(); g++; end
        check_val("slow_thr_seen", (g < 60), 1);
        tx_valid = 1'b0; tx_data = 8'h00;
        g = 0;
        while (!tx_ready && g < 20) begin tick(); g++; end
        check_val("slow_tx_ready", tx_ready, 1);
        if (log_q.size() > 0) begin
            check_val("slow_thr", {log_q[$].addr, log_q[$].wr, log_q[$].wdata}, {3'd0, 1'b1, 8'h7E});
            check_val("slow_wait", log_q[$].cyc - log_q[$].start, 3);
        end
        lsr_val = 8'h00;
        repeat (30) tick();
        n = 0;
        foreach (log_q[i]) if (log_q[i].wr) n++;
        check_val("slow_one_write", n, 1);
        check_val("slow_one_pulse", txr_cnt - t0, 1);
        measure_gap(1'b0, idle);
        check_val("gap_idle", idle, 4);
        measure_gap(1'b1, idle);
        check_val("gap_irq_idle", idle, 1);
        check_val("bus_stable", stab_err, 0);
        check_val("bus_idle_between", idle_err, 0);

        // 6: reset during an open THR write
        lsr_val = 8'h60; tx_data = 8'h55; tx_valid = 1'b1;
        g = 0;
        while (!(bus_req && bus_write && bus_addr == 3'd0) && g < 80) begin tick(); g++; end
        check_val("rst_thr_seen", (g < 80), 1);
        t0 = txr_cnt;
        rst = 1'b0;
        #1;
        check_val("arst_req", bus_req, 0);
        check_val("arst_init_done", init_done, 0);
        check_val("arst_state", fsm_state, 0);
        tx_valid = 1'b0; lsr_val = 8'h00; ack_delay = 0;
        repeat (4) tick();
        log_q.delete();
        rst = 1'b1;
        init_check();
        check_val("arst_no_pulse", txr_cnt - t0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/osd_uart_16550_host.md
Name: osd_uart_16550_host

Overview:
Bus initiator that drives a 16550-style register interface: 3-bit address, 8-bit data, req/ack handshake. After reset it programs the line, divisor, IER and FCR registers, then polls LSR. It moves bytes between valid/ready byte streams and the RBR/THR registers. It sits on the software-facing side of a 16550 UART model and replaces a CPU driver in subsystem tests and host-bridge paths.

Parameters:
DIVISOR, 16'h0001, value written to DLL (low byte) and DLM (high byte) during init
LCR_VAL, 8'h03, line control value (8N1); bit 7 is ignored and forced as required
IER_VAL, 8'h00, interrupt enable value written during init
FCR_VAL, 8'h07, FIFO control value written during init
POLL_GAP, 4, idle cycles between LSR polls that find no work (0 = next poll after mandatory idle)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
bus_req  out  1  access request
bus_addr  out  3  register address
bus_write  out  1  1 = write, 0 = read
bus_wdata  out  8  write data
bus_ack  in  1  access completes in a cycle with bus_req=1 and bus_ack=1
bus_rdata  in  8  read data, valid in the ack cycle
irq  in  1  UART interrupt; cuts the current poll gap short
tx_valid  in  1  TX byte available
tx_data  in  8  TX byte, stable while tx_valid=1 and tx_ready=0
tx_ready  out  1  one-cycle pulse: byte accepted (THR write acked)
rx_valid  out  1  RX holding register full
rx_data  out  8  RX byte
rx_ready  in  1  consumer accepts rx_data
init_done  out  1  high once init completes; stays high until reset

Behaviour:
- All outputs are registered. Reset values: bus_req=0, bus_addr=0, bus_write=0, bus_wdata=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0, FSM=INIT_LCRD, gap counter=0.
- Bus rules:
  - bus_addr, bus_write and bus_wdata are stable for the whole time bus_req=1.
  - bus_req drops on the edge after the ack cycle.
  - At least 1 idle cycle (bus_req=0) separates accesses.
  - Wait for ack indefinitely; there is no timeout.
  - Read data is sampled only in the ack cycle.
- Init writes, in this order (each is one access):
  - INIT_LCRD: addr 3, data {1, LCR_VAL[6:0]}
  - INIT_DLL: addr 0, data DIVISOR[7:0]
  - INIT_DLM: addr 1, data DIVISOR[15:8]
  - INIT_LCR: addr 3, data {0, LCR_VAL[6:0]}
  - INIT_IER: addr 1, data IER_VAL
  - INIT_FCR: addr 2, data FCR_VAL
- With an immediate ack, bus_req is high in cycles 1, 3, 5, 7, 9 and 11 after reset release. init_done rises at cycle 12, together with entering POLL.
- POLL: read addr 5 (LSR). Decision in the ack cycle, using rdata:
  - LSR[0]=1 and rx_valid=0 → RD_RBR.
  - Otherwise LSR[5]=1 and tx_valid=1 → latch tx_data into the write register → WR_THR.
  - Otherwise → GAP.
  - RX has priority over TX.
- RD_RBR: read addr 0. In the ack cycle, load rx_data=bus_rdata; rx_valid goes high on the next edge. Then return to POLL without a gap.
- WR_THR: write addr 0 with the latched byte. tx_ready=1 in the cycle after the ack, for exactly 1 cycle. Then return to POLL.
- GAP:
  - Load the counter with POLL_GAP and count down once per cycle; go to POLL when it reaches 0.
  - irq=1 in any GAP cycle → go to POLL on the next edge.
- RX holding register:
  - Cleared when rx_valid and rx_ready are both 1.
  - Never overwritten while full. When LSR[0]=1 but rx_valid=1, RBR is not read (backpressure) and the FSM goes to GAP.
- TX byte acceptance:
  - A byte is consumed only by tx_ready.
  - A tx_valid deassertion during WR_THR does not abort the write.
- LSR other bits are ignored.
- Reset asserted mid-operation:
  - All registers return to reset values immediately, asynchronously.
  - An in-flight access is abandoned: bus_req drops and no tx_ready pulse occurs.
  - Buffered RX data is lost.
  - Init restarts from INIT_LCRD after release.

Test Plan:
1. DIVISOR=16'h0102, LCR_VAL=8'h03, immediate ack, reset released → writes (3,83),(0,02),(1,01),(3,03),(1,00),(2,07) in cycles 1,3,…,11; init_done=1 at cycle 12; LSR read at cycle 13.
2. LSR returns 8'h01, RBR returns 8'h5A, rx_ready held 0 → rx_valid=1, rx_data=8'h5A; later polls never access addr 0; rx_ready pulse → rx_valid=0, next poll reads RBR.
3. tx_valid=1, tx_data=8'h41, LSR=8'h60 → write to addr 0 with 8'h41; tx_ready high for exactly one cycle after the ack; no second write with tx_valid dropped.
4. LSR=8'h61, tx_valid=1, rx empty → sequence is LSR read, RBR read, LSR read, THR write.
5. Ack delayed 3 cycles on each access → bus_req, bus_addr and bus_wdata constant across the wait; ≥1 idle cycle between accesses; POLL_GAP=4 with no work gives 4 idle cycles, cut to 1 by an irq pulse.
6. rst driven low while WR_THR has bus_req=1 → bus_req=0 in the same cycle, no tx_ready pulse, init_done=0; after release the init sequence repeats from test 1.
